// File: rtl/glitch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : glitch_pkg
// Brief    : Shared state encoding and default widths for the glitch scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package glitch_pkg;

    localparam int c_dly_w = 16;
    localparam int c_len_w = 8;
    localparam int c_num_w = 4;

    typedef enum logic [2:0] {
        GS_IDLE   = 3'd0,
        GS_ARMED  = 3'd1,
        GS_DELAY  = 3'd2,
        GS_GLITCH = 3'd3,
        GS_GAP    = 3'd4,
        GS_DONE   = 3'd5
    } gs_state_t;

    function automatic logic is_busy(input gs_state_t st);
        return (st == GS_DELAY) || (st == GS_GLITCH) || (st == GS_GAP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : 1-bit two-flop synchronizer, asynchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule
`default_nettype wire

// File: rtl/glitch_sched.sv
`default_nettype none
// ============================================================================
// Module   : glitch_sched
// Brief    : Trigger-to-glitch scheduler driving the SoC clock-select line.
// Revision : 1.0 - initial release
// ============================================================================
module glitch_sched
    import glitch_pkg::*;
#(
    parameter int DLY_W = c_dly_w,
    parameter int LEN_W = c_len_w,
    parameter int NUM_W = c_num_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             trig_i,
    input  logic [DLY_W-1:0] delay_i,
    input  logic [LEN_W-1:0] width_i,
    input  logic [LEN_W-1:0] gap_i,
    input  logic [NUM_W-1:0] num_i,
    output logic             clk_sel_o,
    output logic             armed_o,
    output logic             busy_o,
    output logic             done_o
);

    gs_state_t        r_state, w_next_state;
    logic             w_sync2, r_sync2_q, w_rise;
    logic [DLY_W-1:0] r_dly_sh, w_dly_sh, r_dcnt, w_dcnt;
    logic [LEN_W-1:0] r_wid_sh, w_wid_sh, r_gap_sh, w_gap_sh;
    logic [LEN_W-1:0] r_wcnt, w_wcnt, r_gcnt, w_gcnt;
    logic [NUM_W-1:0] r_num_sh, w_num_sh, r_ncnt, w_ncnt;
    logic             r_clk_sel, w_clk_sel;

    sync_2ff u_trig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (trig_i),
        .q_o   (w_sync2)
    );

    assign w_rise = w_sync2 & ~r_sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= GS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync2_q <= 1'b0;
            r_dly_sh  <= '0;
            r_wid_sh  <= '0;
            r_gap_sh  <= '0;
            r_num_sh  <= '0;
            r_dcnt    <= '0;
            r_wcnt    <= '0;
            r_gcnt    <= '0;
            r_ncnt    <= '0;
            r_clk_sel <= 1'b0;
        end else begin
            r_sync2_q <= w_sync2;
            r_dly_sh  <= w_dly_sh;
            r_wid_sh  <= w_wid_sh;
            r_gap_sh  <= w_gap_sh;
            r_num_sh  <= w_num_sh;
            r_dcnt    <= w_dcnt;
            r_wcnt    <= w_wcnt;
            r_gcnt    <= w_gcnt;
            r_ncnt    <= w_ncnt;
            r_clk_sel <= w_clk_sel;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_dly_sh     = r_dly_sh;
        w_wid_sh     = r_wid_sh;
        w_gap_sh     = r_gap_sh;
        w_num_sh     = r_num_sh;
        w_dcnt       = r_dcnt;
        w_wcnt       = r_wcnt;
        w_gcnt       = r_gcnt;
        w_ncnt       = r_ncnt;
        w_clk_sel    = r_clk_sel;

        if (abort_i) begin
            w_next_state = GS_IDLE;
            w_clk_sel    = 1'b0;
        end else begin
            case (r_state)
                GS_IDLE: begin
                    if (arm_i) begin
                        w_next_state = GS_ARMED;
                        // Zero lengths/counts mean "one", so the burst is never empty.
                        w_dly_sh = delay_i;
                        w_wid_sh = (width_i == '0) ? LEN_W'(1) : width_i;
                        w_gap_sh = (gap_i == '0) ? LEN_W'(1) : gap_i;
                        w_num_sh = (num_i == '0) ? NUM_W'(1) : num_i;
                    end
                end
                GS_ARMED: begin
                    if (w_rise) begin
                        w_next_state = GS_DELAY;
                        w_dcnt       = r_dly_sh;
                        w_ncnt       = r_num_sh;
                    end
                end
                GS_DELAY: begin
                    if (r_dcnt == '0) begin
                        w_next_state = GS_GLITCH;
                        w_wcnt       = r_wid_sh - LEN_W'(1);
                        w_clk_sel    = 1'b1;
                    end else begin
                        w_dcnt = r_dcnt - DLY_W'(1);
                    end
                end
                GS_GLITCH: begin
                    if (r_wcnt == '0) begin
                        w_clk_sel = 1'b0;
                        if (r_ncnt != '0) begin
                            w_ncnt = r_ncnt - NUM_W'(1);
                        end
                        if (r_ncnt <= NUM_W'(1)) begin
                            w_next_state = GS_DONE;
                        end else begin
                            w_next_state = GS_GAP;
                            w_gcnt       = r_gap_sh - LEN_W'(1);
                        end
                    end else begin
                        w_wcnt = r_wcnt - LEN_W'(1);
                    end
                end
                GS_GAP: begin
                    if (r_gcnt == '0) begin
                        w_next_state = GS_GLITCH;
                        w_wcnt       = r_wid_sh - LEN_W'(1);
                        w_clk_sel    = 1'b1;
                    end else begin
                        w_gcnt = r_gcnt - LEN_W'(1);
                    end
                end
                GS_DONE: begin
                    w_next_state = GS_IDLE;
                end
                default: begin
                    w_next_state = GS_IDLE;
                    w_clk_sel    = 1'b0;
                end
            endcase
        end
    end

    // clk_sel_o must be a bare flop output: it feeds the clock mux select.
    assign clk_sel_o = r_clk_sel;
    assign armed_o   = (r_state == GS_ARMED);
    assign busy_o    = is_busy(r_state);
    assign done_o    = (r_state == GS_DONE);

endmodule
`default_nettype wire

// File: tb/tb_glitch_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_glitch_sched
// Brief    : Self-checking bench for glitch_sched (tables, random, corners).
// Revision : 1.0 - initial release
// ============================================================================
module tb_glitch_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        trig_i = 1'b0;
    logic [15:0] delay_i = '0;
    logic [7:0]  width_i = '0;
    logic [7:0]  gap_i = '0;
    logic [3:0]  num_i = '0;
    logic        clk_sel_o, armed_o, busy_o, done_o;

    int total = 0;
    int bad = 0;

    typedef struct {
        int d;
        int w;
        int g;
        int n;
        int exp_rise;
        int exp_done;
    } vec_t;

    vec_t tbl[6];

    glitch_sched #(.DLY_W(16), .LEN_W(8), .NUM_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm_i     (arm_i),
        .abort_i   (abort_i),
        .trig_i    (trig_i),
        .delay_i   (delay_i),
        .width_i   (width_i),
        .gap_i     (gap_i),
        .num_i     (num_i),
        .clk_sel_o (clk_sel_o),
        .armed_o   (armed_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int nz(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Reference: offset (edges after trigger sample) at which glitch i begins.
    function automatic bit model_sel(input int c, input int d, input int w, input int g, input int n);
        int start;
        for (int i = 0; i < nz(n); i++) begin
            start = 3 + d + i * (nz(w) + nz(g));
            if (c >= start && c < start + nz(w)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int model_done(input int d, input int w, input int g, input int n);
        return 3 + d + nz(n) * nz(w) + (nz(n) - 1) * nz(g);
    endfunction

    task automatic do_arm(input int d, input int w, input int g, input int n);
        @(negedge clk);
        trig_i  = 1'b0;
        abort_i = 1'b0;
        repeat (3) @(negedge clk);
        delay_i = 16'(d);
        width_i = 8'(w);
        gap_i   = 8'(g);
        num_i   = 4'(n);
        arm_i   = 1'b1;
        @(negedge clk);
        arm_i   = 1'b0;
        // Config churn after arming must not reach the shadow registers.
        delay_i = 16'($urandom);
        width_i = 8'($urandom);
        gap_i   = 8'($urandom);
        num_i   = 4'($urandom);
        check("armed", int'(armed_o), 1);
    endtask

    task automatic watch(input int d, input int w, input int g, input int n, input bit noise,
                         output int rise_obs, output int done_obs);
        int done_ofs;
        int wave_err;
        done_ofs = model_done(d, w, g, n);
        rise_obs = -1;
        done_obs = -1;
        wave_err = 0;
        trig_i   = 1'b1;
        for (int c = 0; c <= done_ofs + 3; c++) begin
            @(negedge clk);
            if (clk_sel_o && rise_obs < 0) rise_obs = c;
            if (done_o && done_obs < 0) done_obs = c;
            if (clk_sel_o !== model_sel(c, d, w, g, n)) wave_err++;
            if (done_o !== (c == done_ofs)) wave_err++;
            if (busy_o !== (c >= 2 && c < done_ofs)) wave_err++;
            if (armed_o !== (c < 2)) wave_err++;
            trig_i = 1'b0;
            arm_i  = 1'b0;
            if (noise && c >= 2 && c < done_ofs) begin
                trig_i  = 1'($urandom);
                arm_i   = ($urandom_range(0, 3) == 0);
                delay_i = 16'($urandom);
                width_i = 8'($urandom);
                num_i   = 4'($urandom);
            end
        end
        trig_i = 1'b0;
        arm_i  = 1'b0;
        check("wave", wave_err, 0);
        check("first_rise", rise_obs, 3 + d);
        check("done_at", done_obs, done_ofs);
    endtask

    initial begin
        int r, dn, cnt, d, w, g, n;

        tbl[0] = '{d: 5,  w: 2, g: 3, n: 3, exp_rise: 8,  exp_done: 20};
        tbl[1] = '{d: 0,  w: 0, g: 0, n: 0, exp_rise: 3,  exp_done: 4};
        tbl[2] = '{d: 1,  w: 1, g: 1, n: 2, exp_rise: 4,  exp_done: 7};
        tbl[3] = '{d: 0,  w: 3, g: 0, n: 2, exp_rise: 3,  exp_done: 10};
        tbl[4] = '{d: 2,  w: 1, g: 4, n: 1, exp_rise: 5,  exp_done: 6};
        tbl[5] = '{d: 10, w: 4, g: 2, n: 4, exp_rise: 13, exp_done: 35};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_clk_sel", int'(clk_sel_o), 0);
        check("rst_armed", int'(armed_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);

        for (int i = 0; i < 6; i++) begin
            do_arm(tbl[i].d, tbl[i].w, tbl[i].g, tbl[i].n);
            watch(tbl[i].d, tbl[i].w, tbl[i].g, tbl[i].n, 1'b0, r, dn);
            check("tbl_rise", r, tbl[i].exp_rise);
            check("tbl_done", dn, tbl[i].exp_done);
        end

        // Trigger edge while idle is forgotten; a later edge fires normally.
        @(negedge clk);
        trig_i = 1'b1;
        @(negedge clk);
        trig_i = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_trig_busy", int'(busy_o), 0);
        do_arm(1, 1, 1, 1);
        repeat (6) @(negedge clk);
        check("idle_trig_armed", int'(armed_o), 1);
        check("idle_trig_sel", int'(clk_sel_o), 0);
        watch(1, 1, 1, 1, 1'b0, r, dn);

        // Abort during the second glitch (c=8..10) of an N=4 burst.
        do_arm(0, 3, 2, 4);
        trig_i = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            trig_i = 1'b0;
        end
        check("abort_pre_sel", int'(clk_sel_o), 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_sel", int'(clk_sel_o), 0);
        check("abort_busy", int'(busy_o), 0);
        check("abort_armed", int'(armed_o), 0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_o || clk_sel_o || busy_o) cnt++;
        end
        check("abort_quiet", cnt, 0);

        // Arm and abort together: abort wins.
        arm_i   = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        arm_i   = 1'b0;
        abort_i = 1'b0;
        check("arm_abort", int'(armed_o), 0);

        // Noisy trigger and stray arm pulses while busy leave timing unchanged.
        for (int it = 0; it < 25; it++) begin
            d = $urandom_range(0, 20);
            w = $urandom_range(0, 5);
            g = $urandom_range(0, 5);
            n = $urandom_range(0, 5);
            do_arm(d, w, g, n);
            watch(d, w, g, n, 1'b1, r, dn);
        end

        // Asynchronous reset while a glitch window is open.
        do_arm(0, 8, 1, 1);
        trig_i = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            trig_i = 1'b0;
        end
        check("rst_pre_sel", int'(clk_sel_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sel", int'(clk_sel_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out", int'({clk_sel_o, armed_o, busy_o, done_o}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/glitch_sched.md
# glitch_sched

Glitch-clock scheduler for the CW305 PULPino top. It owns the `clk_sel` control that switches the SoC clock between `clk` and `clk_glitch`. After being armed by the host, it waits for a rising edge on the SoC trigger GPIO (`gpio_out[4]`), counts a programmable delay, then drives a programmable burst of glitch windows on `clk_sel_o`. It sits in the CW305 wrapper between the host register bank and the SoC clock mux.

## Interface
Parameters:
- `DLY_W`, 16: width of the trigger-to-first-glitch delay counter.
- `LEN_W`, 8: width of the glitch-width and gap counters.
- `NUM_W`, 4: width of the glitch repeat count.

Ports:
- `clk`  in  1  free-running board clock, never glitched; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `arm_i`  in  1  single-cycle host arm pulse; latches config.
- `abort_i`  in  1  host abort; level-sensitive, highest priority.
- `trig_i`  in  1  SoC trigger (`gpio_out[4]`); asynchronous to `clk`.
- `delay_i`  in  DLY_W  cycles from detected trigger to first glitch.
- `width_i`  in  LEN_W  cycles `clk_sel_o` is high per glitch; 0 treated as 1.
- `gap_i`  in  LEN_W  low cycles between glitches; 0 treated as 1.
- `num_i`  in  NUM_W  number of glitches; 0 treated as 1.
- `clk_sel_o`  out  1  registered select: 1 = `clk_glitch`, 0 = `clk`.
- `armed_o`  out  1  high while waiting for the trigger.
- `busy_o`  out  1  high in DELAY, GLITCH, GAP.
- `done_o`  out  1  one-cycle pulse when the burst completes.

## Operation
- `trig_i` passes through a 2-flop synchronizer, then a registered edge detector: `rise = sync2 & ~sync2_q`.
- States:
  - IDLE. `arm_i` → ARMED; latch `delay_i`, `width_i`, `gap_i`, `num_i` into shadow registers, with the 0→1 substitution applied.
  - ARMED. `rise` → DELAY; load `dcnt` = delay.
  - DELAY. `dcnt`==0 → GLITCH; load `wcnt` = width−1 and set `clk_sel_o`. Otherwise decrement `dcnt`.
  - GLITCH. `wcnt`==0: clear `clk_sel_o` and decrement `ncnt`. Then, if `ncnt`==1 (last glitch) → DONE; else → GAP with `gcnt` = gap−1. Otherwise decrement `wcnt`.
  - GAP. `gcnt`==0 → GLITCH; reload `wcnt` and set `clk_sel_o`. Otherwise decrement `gcnt`.
  - DONE. Assert `done_o` for one cycle, then → IDLE.
- `abort_i` high: from any state → IDLE at the next edge. `clk_sel_o` is cleared on that edge and `done_o` does not pulse.
- `arm_i` is ignored outside IDLE.
- Trigger edges are ignored outside ARMED; edges seen in IDLE are not remembered.
- `arm_i` and `abort_i` asserted in the same cycle: abort wins; the block stays in IDLE.
- Counters never wrap: each counter is loaded once per phase and decremented only while non-zero.
- Config inputs may change at any time without effect until the next arm.

## Timing
- Reset values: state IDLE; `clk_sel_o`=0, `armed_o`=0, `busy_o`=0, `done_o`=0; synchronizer flops and all counters 0.
- `trig_i` first sampled high at edge k:
  - `rise` is valid after edge k+1;
  - DELAY is entered at edge k+2;
  - `clk_sel_o` rises at edge k+3+D, where D is the latched delay.
- Each glitch: `clk_sel_o` is high for exactly W cycles, then low for exactly G cycles before the next glitch.
- After the last glitch: `clk_sel_o` falls, the block spends one cycle in DONE, and `done_o` is high during that cycle.
- Total burst length from first rise to last fall: N·W + (N−1)·G cycles.
- `clk_sel_o` comes straight from a flop with no combinational path from any input; the downstream clock mux relies on this.
- A reset mid-burst forces `clk_sel_o` low asynchronously.

## Structure
- `glitch_pkg`: the state enum (`GS_IDLE`, `GS_ARMED`, `GS_DELAY`, `GS_GLITCH`, `GS_GAP`, `GS_DONE`) and default values for the width parameters.
- Sub-module `sync_2ff`: a 1-bit two-flop synchronizer with asynchronous active-low reset, reusable for the other asynchronous inputs of the wrapper.
- All remaining logic (FSM, counters, shadow config) lives in `glitch_sched`.

## Test plan
- Arm with D=5, W=2, G=3, N=3; pulse `trig_i` high at edge k → `clk_sel_o` is high during cycles k+8..k+9, k+13..k+14 and k+18..k+19; `done_o` pulses at k+20; state returns to IDLE.
- Arm with all-zero config; trigger at edge k → `clk_sel_o` is high for exactly one cycle at edge k+3; `done_o` pulses the next cycle.
- Trigger while in IDLE, then arm → no glitch, `armed_o`=1. A second trigger edge then starts the burst normally.
- Assert `abort_i` during the second glitch of an N=4 burst → `clk_sel_o` low at the next edge, IDLE, `done_o` never pulses.
- Toggle `trig_i` repeatedly during DELAY and GAP, and pulse `arm_i` while `busy_o`=1 → timing is identical to the single-trigger case.
- Deassert `rst_n` asynchronously while `clk_sel_o`=1 → `clk_sel_o` falls immediately without waiting for a clock edge; all outputs 0 after reset release.
